// File: rtl/hdmi_sched_pkg.sv
// -----------------------------------------------------------------------------
// hdmi_sched_pkg
// Shared definitions for the HDMI data-island packet scheduler:
//   - PKT_* : 8-bit packet type codes driven to the hdmi core
//   - src_e : packet sources; the numeric value is the grant bit index
//   - state_e : scheduler FSM states
//   - src_onehot() : source -> one-hot grant vector {AIF,AVI,AUD,ACR}
// Optional feature macro used by the scheduler: HDMI_SCHED_STATS_EN
// -----------------------------------------------------------------------------
package hdmi_sched_pkg;

    localparam logic [7:0] PKT_NULL = 8'h00;
    localparam logic [7:0] PKT_ACR  = 8'h01;
    localparam logic [7:0] PKT_AUD  = 8'h02;
    localparam logic [7:0] PKT_AVI  = 8'h82;
    localparam logic [7:0] PKT_AIF  = 8'h84;

    typedef enum logic [1:0] {
        SRC_ACR = 2'd0,
        SRC_AUD = 2'd1,
        SRC_AVI = 2'd2,
        SRC_AIF = 2'd3
    } src_e;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SLOT = 1'b1
    } state_e;

    function automatic logic [3:0] src_onehot(input src_e src);
        return 4'b0001 << src;
    endfunction

endpackage

// File: rtl/packet_priority_picker.sv
// -----------------------------------------------------------------------------
// packet_priority_picker
// Purely combinational priority selection of the next data-island packet.
// Order: urgent audio -> ACR -> AVI InfoFrame -> Audio InfoFrame -> audio -> null.
// Ports:
//   acr_p, avi_p, aif_p  in   pending request flags
//   audio_level          in   samples waiting in the audio buffer
//   pick_valid           out  1 when a real (non-null) packet was chosen
//   pick_src             out  chosen source (meaningful only when pick_valid)
//   pick_type            out  packet type code of the choice (PKT_NULL if none)
// -----------------------------------------------------------------------------
module packet_priority_picker
    import hdmi_sched_pkg::*;
#(
    parameter int LEVEL_WIDTH  = 6,
    parameter int URGENT_LEVEL = 8
) (
    input  logic                   acr_p,
    input  logic                   avi_p,
    input  logic                   aif_p,
    input  logic [LEVEL_WIDTH-1:0] audio_level,
    output logic                   pick_valid,
    output src_e                   pick_src,
    output logic [7:0]             pick_type
);

    logic audio_urgent;
    logic audio_any;

    assign audio_urgent = (audio_level >= LEVEL_WIDTH'(URGENT_LEVEL));
    assign audio_any    = (audio_level != '0);

    always_comb begin
        pick_valid = 1'b1;
        pick_src   = SRC_ACR;
        pick_type  = PKT_NULL;
        if (audio_urgent) begin
            pick_src  = SRC_AUD;
            pick_type = PKT_AUD;
        end else if (acr_p) begin
            pick_src  = SRC_ACR;
            pick_type = PKT_ACR;
        end else if (avi_p) begin
            pick_src  = SRC_AVI;
            pick_type = PKT_AVI;
        end else if (aif_p) begin
            pick_src  = SRC_AIF;
            pick_type = PKT_AIF;
        end else if (audio_any) begin
            pick_src  = SRC_AUD;
            pick_type = PKT_AUD;
        end else begin
            pick_valid = 1'b0;
        end
    end

endmodule

// File: rtl/packet_scheduler.sv
// -----------------------------------------------------------------------------
// packet_scheduler
// Chooses which HDMI data-island packet the hdmi core sends in each packet
// slot (ACR, audio sample, AVI InfoFrame, Audio InfoFrame or null), in the
// clk_pixel domain.
// Optional feature: define HDMI_SCHED_STATS_EN to add grant counters and the
// sticky infoframe_miss flag.
// Ports:
//   clk_pixel, reset_n   clock, asynchronous active-low reset
//   packet_enable        slot start pulse from the hdmi core
//   frame_start          frame pulse, re-arms both InfoFrames
//   acr_tick             ACR packet due
//   audio_level          samples waiting in the audio buffer
//   packet_type          registered packet type for the next/current slot
//   grant                one-hot {AIF,AVI,AUD,ACR}, pulse after packet_enable
//   audio_pop            pulse with grant[AUD], audio_pop_count samples
//   protocol_error       sticky: packet_enable arrived inside a slot
//   grant_count_*        (stats) wrapping per-source grant counters
//   infoframe_miss       (stats) sticky: frame_start while an InfoFrame pending
//   state_dbg            current FSM state, for observation only
// -----------------------------------------------------------------------------
module packet_scheduler
    import hdmi_sched_pkg::*;
#(
    parameter int SLOT_CYCLES  = 32,
    parameter int LEVEL_WIDTH  = 6,
`ifdef HDMI_SCHED_STATS_EN
    parameter int STAT_WIDTH   = 16,
`endif
    parameter int URGENT_LEVEL = 8
) (
    input  logic                   clk_pixel,
    input  logic                   reset_n,
    input  logic                   packet_enable,
    input  logic                   frame_start,
    input  logic                   acr_tick,
    input  logic [LEVEL_WIDTH-1:0] audio_level,
    output logic [7:0]             packet_type,
    output logic [3:0]             grant,
    output logic                   audio_pop,
    output logic [2:0]             audio_pop_count,
    output logic                   protocol_error,
`ifdef HDMI_SCHED_STATS_EN
    output logic [STAT_WIDTH-1:0]  grant_count_acr,
    output logic [STAT_WIDTH-1:0]  grant_count_aud,
    output logic [STAT_WIDTH-1:0]  grant_count_avi,
    output logic [STAT_WIDTH-1:0]  grant_count_aif,
    output logic                   infoframe_miss,
`endif
    output state_e                 state_dbg
);

    // Handshake: packet_enable is a one-cycle offer of a slot. It is accepted
    // only in IDLE, where the packet_type shown in that same cycle is the one
    // committed; grant (and audio_pop) answer exactly one cycle later. There
    // is no back-pressure: an offer made during SLOT is dropped and flagged.

    localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);

    state_e           state;
    logic [CNT_W-1:0] slot_cnt;
    logic             acr_p, avi_p, aif_p;
    src_e             cur_src;
    logic             cur_valid;

    logic             pick_valid;
    src_e             pick_src;
    logic [7:0]       pick_type;

    logic             accept;
    logic             clr_acr, clr_avi, clr_aif;
    logic             slot_done;

    assign state_dbg = state;

    packet_priority_picker #(
        .LEVEL_WIDTH  (LEVEL_WIDTH),
        .URGENT_LEVEL (URGENT_LEVEL)
    ) u_picker (
        .acr_p       (acr_p),
        .avi_p       (avi_p),
        .aif_p       (aif_p),
        .audio_level (audio_level),
        .pick_valid  (pick_valid),
        .pick_src    (pick_src),
        .pick_type   (pick_type)
    );

    assign accept    = (state == IDLE) && packet_enable;
    assign slot_done = (state == SLOT) && (slot_cnt == SLOT_LAST);

    // Flags are consumed on the accept edge so that a request arriving in the
    // same cycle (including a frame_start re-arm) survives via set-wins.
    assign clr_acr = accept && cur_valid && (cur_src == SRC_ACR);
    assign clr_avi = accept && cur_valid && (cur_src == SRC_AVI);
    assign clr_aif = accept && cur_valid && (cur_src == SRC_AIF);

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            acr_p <= 1'b0;
            avi_p <= 1'b0;
            aif_p <= 1'b0;
        end else begin
            acr_p <= acr_tick    | (acr_p & ~clr_acr);
            avi_p <= frame_start | (avi_p & ~clr_avi);
            aif_p <= frame_start | (aif_p & ~clr_aif);
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            slot_cnt        <= '0;
            packet_type     <= PKT_NULL;
            cur_src         <= SRC_ACR;
            cur_valid       <= 1'b0;
            grant           <= 4'b0000;
            audio_pop       <= 1'b0;
            audio_pop_count <= 3'd0;
            protocol_error  <= 1'b0;
        end else begin
            grant           <= 4'b0000;
            audio_pop       <= 1'b0;
            audio_pop_count <= 3'd0;

            if (packet_enable && (state == SLOT)) begin
                protocol_error <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (packet_enable) begin
                        state    <= SLOT;
                        slot_cnt <= '0;
                        if (cur_valid) begin
                            grant <= src_onehot(cur_src);
                        end
                        if (cur_valid && (cur_src == SRC_AUD) && (audio_level != '0)) begin
                            audio_pop       <= 1'b1;
                            audio_pop_count <= (audio_level >= LEVEL_WIDTH'(4)) ? 3'd4
                                                                                : audio_level[2:0];
                        end
                    end else begin
                        packet_type <= pick_type;
                        cur_src     <= pick_src;
                        cur_valid   <= pick_valid;
                    end
                end
                SLOT: begin
                    if (slot_done) begin
                        // Reload on exit so a back-to-back packet_enable in the
                        // first IDLE cycle sees a fresh pick, not the old slot.
                        state       <= IDLE;
                        slot_cnt    <= '0;
                        packet_type <= pick_type;
                        cur_src     <= pick_src;
                        cur_valid   <= pick_valid;
                    end else begin
                        slot_cnt <= slot_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef HDMI_SCHED_STATS_EN
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            grant_count_acr <= '0;
            grant_count_aud <= '0;
            grant_count_avi <= '0;
            grant_count_aif <= '0;
            infoframe_miss  <= 1'b0;
        end else begin
            if (grant[SRC_ACR]) grant_count_acr <= grant_count_acr + 1'b1;
            if (grant[SRC_AUD]) grant_count_aud <= grant_count_aud + 1'b1;
            if (grant[SRC_AVI]) grant_count_avi <= grant_count_avi + 1'b1;
            if (grant[SRC_AIF]) grant_count_aif <= grant_count_aif + 1'b1;
            if (frame_start && (avi_p || aif_p)) begin
                infoframe_miss <= 1'b1;
            end
        end
    end
`endif

endmodule
